narb_rr_arb: RTL and testbench
==============================

Name: narb_rr_arb

Overview:
- Packet-aware round-robin arbiter that drains N narb_fifo instances (first-word-fall-through: data valid on dataout while empty_o=0) onto one registered output link with valid/ready handshake.
- Sits directly downstream of the per-input narb_fifo bank in a NoC router port.
- Holds a grant for the whole packet, head through tail flit, so flits from different inputs never interleave.

Parameters:
- N_IN, 4, number of upstream FIFOs (2..8).
- LOG2_N_IN, 2, log2 of N_IN; width of grant index and round-robin pointer.
- FLIT_WIDTH, 8, width of each flit; matches the FIFO BUF_WIDTH.
- TAIL_BIT, 7, bit index inside a flit that marks the last flit of a packet.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fifo_empty_i  in  N_IN  empty_o of each upstream FIFO.
- fifo_data_i  in  N_IN*FLIT_WIDTH  dataout of each FIFO; input k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH].
- fifo_rd_o  out  N_IN  enr to each FIFO; combinational; one-hot or zero.
- out_valid_o  out  1  output flit valid.
- out_data_o  out  FLIT_WIDTH  output flit.
- out_ready_i  in  1  downstream accepts the flit when out_valid_o=1 and out_ready_i=1.
- grant_o  out  LOG2_N_IN  index of the input that sourced the current or locked packet.
- locked_o  out  1  high while the arbiter is mid-packet (state LOCKED).

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, grant_o=0, locked_o=0, rr_ptr=0, state=IDLE. fifo_rd_o=0 during any cycle with rst=1.
- Slot free: slot_free = !out_valid_o || out_ready_i.
- Pop rule: fifo_rd_o[k]=1 only when all of the following hold:
  - k is the selected input;
  - fifo_empty_i[k]=0;
  - slot_free=1;
  - rst=0.
  - Reading an empty FIFO is a fatal error in the FIFO, so this is a hard invariant.
- Pop timing: on the edge of a pop cycle, out_data_o <= the selected flit and out_valid_o <= 1. Latency is 1 cycle from FIFO head to output register.
- Drain without pop: if out_ready_i=1 and no pop occurs, out_valid_o <= 0. out_data_o holds its value.
- State IDLE:
  - Selection: the first non-empty input found scanning rr_ptr, rr_ptr+1, ... modulo N_IN.
  - If no input is non-empty, or slot_free=0: no pop, no state change.
  - On a pop from input g: grant_o <= g.
  - If the popped flit[TAIL_BIT]=1 (single-flit packet): stay IDLE and set rr_ptr <= (g+1) mod N_IN.
  - If the popped flit[TAIL_BIT]=0: go to LOCKED and set locked_o <= 1.
- State LOCKED:
  - The selected input is always grant_o; other inputs are ignored even when non-empty.
  - If grant_o is empty, or slot_free=0: stall, with no pop and no timeout.
  - On a pop where the flit[TAIL_BIT]=1: go to IDLE, locked_o <= 0, rr_ptr <= (grant_o+1) mod N_IN.
- Wrap-around: rr_ptr and the selection scan wrap from N_IN-1 to 0.
- Back-to-back throughput: 1 flit per cycle while out_ready_i=1. A tail pop and the next packet's head pop occur on consecutive cycles, with no bubble.
- Simultaneous output drain and pop: the output register is replaced in the same cycle, and out_valid_o stays 1.
- Reset mid-packet: state returns to IDLE and rr_ptr to 0. Any flits already popped are lost; upstream FIFOs are reset by the same rst.
- Combinational paths: fifo_rd_o depends on out_ready_i and fifo_empty_i. There is no combinational path from fifo_data_i to any output except through the tail-bit-independent pop logic.

Test Plan:
- Single-flit packets, fair sharing: all 4 inputs hold single-flit packets 0x80|k, out_ready=1, after reset -> output order 0x80,0x81,0x82,0x83,0x80... on consecutive cycles.
- Packet locking:
  - Stimulus: input 1 holds 3-flit packet 0x11,0x12,0x93; input 0 holds 0x85 and becomes non-empty mid-packet; rr_ptr=1.
  - Required response: 0x11,0x12,0x93 are output contiguously, then 0x85; locked_o is high for exactly the 0x11 and 0x12 pop cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with out_valid=1.
  - Required response: fifo_rd_o=0 throughout and out_data_o is held; on the first ready cycle, the next flit is popped in that same cycle.
- Locked stall on empty grant:
  - Stimulus: input 2 sends head 0x20, its FIFO then empties for 4 cycles while input 3 is non-empty.
  - Required response: no pops from input 3; the packet resumes when input 2 refills; fifo_rd_o never hits an empty input (assertion).
- Wrap-around: only inputs 3 and 0 active with single-flit packets -> alternation 3,0,3,0; grant_o matches the source of each flit.
- Reset mid-packet: assert rst after the head flit of a 4-flit packet -> next cycle out_valid_o=0, locked_o=0, grant_o=0; after release, arbitration starts at input 0.

Source files
------------

// File: rtl/narb_rr_arb.sv
// Packet-aware round-robin arbiter draining N first-word-fall-through FIFOs
// onto one registered valid/ready output link. A grant is held from head
// flit to tail flit so packets from different inputs never interleave.
module narb_rr_arb #(
    parameter int N_IN       = 4,
    parameter int LOG2_N_IN  = 2,
    parameter int FLIT_WIDTH = 8,
    parameter int TAIL_BIT   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN-1:0]            fifo_empty_i,
    input  logic [N_IN*FLIT_WIDTH-1:0] fifo_data_i,
    output logic [N_IN-1:0]            fifo_rd_o,
    output logic                       out_valid_o,
    output logic [FLIT_WIDTH-1:0]      out_data_o,
    input  logic                       out_ready_i,
    output logic [LOG2_N_IN-1:0]       grant_o,
    output logic                       locked_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [LOG2_N_IN:0] N_IN_W = (LOG2_N_IN+1)'(N_IN);

    state_t                  state_q, state_d;
    logic [LOG2_N_IN-1:0]    rr_ptr_q, rr_ptr_d;
    logic [LOG2_N_IN-1:0]    grant_q, grant_d;
    logic                    out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0]   out_data_q, out_data_d;

    logic [LOG2_N_IN-1:0]    cand [N_IN];
    logic                    scan_found;
    logic [LOG2_N_IN-1:0]    scan_idx;
    logic [LOG2_N_IN-1:0]    sel_idx;
    logic                    sel_valid;
    logic [FLIT_WIDTH-1:0]   sel_flit;
    logic                    slot_free;
    logic                    pop;

    // (base + off) modulo N_IN; both operands are already below N_IN.
    function automatic logic [LOG2_N_IN-1:0] wrap_add(
        input logic [LOG2_N_IN-1:0] base,
        input logic [LOG2_N_IN-1:0] off
    );
        logic [LOG2_N_IN:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= N_IN_W) begin
            sum = sum - N_IN_W;
        end
        return sum[LOG2_N_IN-1:0];
    endfunction

    // Candidate input for each scan offset, starting at the round-robin pointer.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_cand
            assign cand[gi] = wrap_add(rr_ptr_q, LOG2_N_IN'(gi));
        end
    endgenerate

    // First non-empty input at or after rr_ptr; walk offsets high-to-low so the
    // closest one wins.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = rr_ptr_q;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (!fifo_empty_i[cand[i]]) begin
                scan_found = 1'b1;
                scan_idx   = cand[i];
            end
        end
    end

    // While locked only the granted input may be read; the data mux is only
    // feeding the output register, never the pop decision.
    always_comb begin
        sel_idx   = (state_q == LOCKED) ? grant_q : scan_idx;
        sel_valid = (state_q == LOCKED) ? !fifo_empty_i[grant_q] : scan_found;
        sel_flit  = fifo_data_i[int'(sel_idx)*FLIT_WIDTH +: FLIT_WIDTH];
        slot_free = !out_valid_q || out_ready_i;
        pop       = sel_valid && slot_free && !rst;
    end

    // One-hot read strobe towards the selected FIFO, never to an empty one.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_rd
            assign fifo_rd_o[gi] = pop && (sel_idx == LOG2_N_IN'(gi));
        end
    endgenerate

    // Next-state: load the output register on a pop, release grant on tail.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_flit;
            grant_d     = sel_idx;
            if (sel_flit[TAIL_BIT]) begin
                state_d  = IDLE;
                rr_ptr_d = wrap_add(sel_idx, LOG2_N_IN'(1));
            end else begin
                state_d  = LOCKED;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign grant_o     = grant_q;
    assign locked_o    = (state_q == LOCKED);

endmodule

// File: tb/tb_narb_rr_arb.sv
// Directed bench for narb_rr_arb: queue-based FIFO/arbiter model checked every
// cycle, plus literal expectations on the output flit stream.
module tb_narb_rr_arb;

    localparam int N  = 4;
    localparam int LG = 2;
    localparam int FW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    fifo_empty_i;
    logic [N*FW-1:0] fifo_data_i;
    logic [N-1:0]    fifo_rd_o;
    logic            out_valid_o;
    logic [FW-1:0]   out_data_o;
    logic            out_ready_i;
    logic [LG-1:0]   grant_o;
    logic            locked_o;

    always #5 clk = ~clk;

    narb_rr_arb #(
        .N_IN(N), .LOG2_N_IN(LG), .FLIT_WIDTH(FW), .TAIL_BIT(7)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
        .fifo_rd_o(fifo_rd_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_ready_i(out_ready_i),
        .grant_o(grant_o), .locked_o(locked_o)
    );

    // Upstream FIFO contents, head at index 0.
    logic [7:0] q [N][$];

    int vectors    = 0;
    int miscompares = 0;

    // Model of the arbiter: owner of the current packet, fairness pointer,
    // and what the output register should hold.
    bit         m_valid  = 1'b0;
    bit         m_locked = 1'b0;
    logic [7:0] m_data   = 8'h00;
    int         m_grant  = 0;
    int         m_ptr    = 0;

    bit chk_en = 1'b0;
    bit cnt_en = 1'b0;
    int lock_cnt = 0;
    int rd_cnt   = 0;
    int rd3_cnt  = 0;

    logic [7:0] log_data[$];
    int         log_grant[$];
    logic [7:0] exp_q[$];
    int         exp_g[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Which input the arbiter should read now, or -1.
    function automatic int pick();
        if (m_locked) begin
            return (q[m_grant].size() > 0) ? m_grant : -1;
        end
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_ptr + o) % N;
            if (q[k].size() > 0) return k;
        end
        return -1;
    endfunction

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            fifo_empty_i[k] = (q[k].size() == 0);
            fifo_data_i[k*FW +: FW] = (q[k].size() > 0) ? q[k][0] : 8'h00;
        end
    endtask

    task automatic model_step();
        int         src;
        bit         slot;
        logic [7:0] f;
        slot = !m_valid || out_ready_i;
        if (rst) begin
            m_valid = 0; m_data = 8'h00; m_grant = 0; m_locked = 0; m_ptr = 0;
        end else begin
            src = pick();
            if (src >= 0 && slot) begin
                f = q[src].pop_front();
                m_valid = 1;
                m_data  = f;
                m_grant = src;
                if (f[7]) begin
                    m_locked = 0;
                    m_ptr    = (src + 1) % N;
                end else begin
                    m_locked = 1;
                end
            end else if (out_ready_i) begin
                m_valid = 0;
            end
        end
    endtask

    // Model and FIFO pops advance on each edge; inputs settle 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1 refresh();
        end
    end

    // Per-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin : cmp
                int         src;
                logic [N-1:0] er;
                chk("out_valid", out_valid_o, m_valid);
                chk("out_data", out_data_o, m_data);
                chk("grant", grant_o, m_grant);
                chk("locked", locked_o, m_locked);
                src = pick();
                er  = '0;
                if (!rst && src >= 0 && (!m_valid || out_ready_i)) er[src] = 1'b1;
                chk("fifo_rd", fifo_rd_o, er);
                chk("rd_on_empty", fifo_rd_o & fifo_empty_i, 0);
                if (out_valid_o && out_ready_i) begin
                    log_data.push_back(out_data_o);
                    log_grant.push_back(int'(grant_o));
                    $display("xfer t=%0t data=%02h grant=%0d locked=%0b", $time, out_data_o, grant_o, locked_o);
                end
                if (cnt_en) begin
                    lock_cnt += int'(locked_o);
                    rd_cnt   += int'(fifo_rd_o != '0);
                    rd3_cnt  += int'(fifo_rd_o[3]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_grant.delete();
    endtask

    task automatic clear_fifos();
        for (int k = 0; k < N; k++) q[k].delete();
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, log_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_data.size()) begin
                chk($sformatf("%s_data[%0d]", name, i), log_data[i], exp_q[i]);
                if (i < exp_g.size())
                    chk($sformatf("%s_grant[%0d]", name, i), log_grant[i], exp_g[i]);
            end
        end
    endtask

    initial begin
        out_ready_i = 1'b1;
        rst = 1'b1;
        clear_fifos();
        refresh();
        cyc(2);
        chk_en = 1'b1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_rd", fifo_rd_o, 0);
        rst = 1'b0;

        // Fair sharing of single-flit packets.
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) q[k].push_back(8'h80 | 8'(k));
        refresh();
        cyc(10);
        exp_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h80, 8'h81, 8'h82, 8'h83};
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("fair");

        // Packet locking: move pointer to 1, then 3-flit packet on input 1.
        q[0].push_back(8'h80);
        refresh();
        cyc(3);
        clear_log();
        lock_cnt = 0;
        cnt_en = 1'b1;
        q[1].push_back(8'h11); q[1].push_back(8'h12); q[1].push_back(8'h93);
        refresh();
        cyc(1);
        q[0].push_back(8'h85);
        refresh();
        cyc(6);
        cnt_en = 1'b0;
        exp_q = '{8'h11, 8'h12, 8'h93, 8'h85};
        exp_g = '{1, 1, 1, 0};
        check_log("lock");
        chk("lock_cycles", lock_cnt, 2);

        // Backpressure: output held, no reads, immediate pop on ready.
        clear_log();
        out_ready_i = 1'b0;
        q[2].push_back(8'hA0); q[2].push_back(8'hA1);
        refresh();
        cyc(1);
        rd_cnt = 0;
        cnt_en = 1'b1;
        cyc(5);
        cnt_en = 1'b0;
        chk("bp_rd_cnt", rd_cnt, 0);
        chk("bp_data", out_data_o, 8'hA0);
        chk("bp_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        #2;
        chk("bp_resume_rd", fifo_rd_o, 4'b0100);
        cyc(4);
        exp_q = '{8'hA0, 8'hA1};
        exp_g = '{2, 2};
        check_log("bp");

        // Locked stall while the granted FIFO is empty.
        rst = 1'b1;
        clear_fifos();
        refresh();
        cyc(2);
        rst = 1'b0;
        clear_log();
        q[2].push_back(8'h20);
        refresh();
        cyc(1);
        q[3].push_back(8'hB0);
        refresh();
        rd3_cnt = 0;
        cnt_en = 1'b1;
        cyc(4);
        cnt_en = 1'b0;
        chk("stall_rd3", rd3_cnt, 0);
        chk("stall_locked", locked_o, 1);
        q[2].push_back(8'h21); q[2].push_back(8'hA2);
        refresh();
        cyc(6);
        exp_q = '{8'h20, 8'h21, 8'hA2, 8'hB0};
        exp_g = '{2, 2, 2, 3};
        check_log("stall");

        // Wrap-around between inputs 3 and 0.
        q[2].push_back(8'hC2);
        refresh();
        cyc(3);
        clear_log();
        q[3].push_back(8'h83); q[3].push_back(8'h84);
        q[0].push_back(8'h90); q[0].push_back(8'h91);
        refresh();
        cyc(6);
        exp_q = '{8'h83, 8'h90, 8'h84, 8'h91};
        exp_g = '{3, 0, 3, 0};
        check_log("wrap");

        // Reset after the head flit of a 4-flit packet.
        q[1].push_back(8'h01); q[1].push_back(8'h02);
        q[1].push_back(8'h03); q[1].push_back(8'h84);
        refresh();
        cyc(1);
        chk("mid_locked_pre", locked_o, 1);
        rst = 1'b1;
        clear_fifos();
        refresh();
        cyc(1);
        chk("mid_valid", out_valid_o, 0);
        chk("mid_locked", locked_o, 0);
        chk("mid_grant", grant_o, 0);
        chk("mid_rd", fifo_rd_o, 0);
        rst = 1'b0;
        clear_log();
        q[0].push_back(8'h8A);
        q[1].push_back(8'h8B);
        refresh();
        cyc(5);
        exp_q = '{8'h8A, 8'h8B};
        exp_g = '{0, 1};
        check_log("post_rst");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
